// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring integer divider for RV32M/RV64M DIV, DIVU, REM, REMU.
// Operands are latched at accept, so the pipeline may change a/b while the unit is busy.
// Divide-by-zero and signed overflow can bypass the iteration loop when EARLY_OUT is set.
module iter_divider #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] quo_q;       // dividend magnitude, shifted out as quotient bits shift in
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] spec_res_q;  // precomputed answer for div-by-zero / overflow
  logic            spec_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            op_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] spec_res;

  // Decode the incoming operands: magnitudes, sign flags and the RISC-V corner-case result.
  always_comb begin
    op_signed = ~funct3[0];
    a_neg     = op_signed & a[XLEN-1];
    b_neg     = op_signed & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div_zero  = (b == '0);
    overflow  = op_signed & (a == MinNeg) & (b == '1);
    special   = div_zero | overflow;
    spec_res  = '0;
    if (div_zero) begin
      spec_res = funct3[1] ? a : '1;
    end else begin
      spec_res = funct3[1] ? '0 : a;
    end
  end

  logic [XLEN:0]   rem_ext;
  logic            ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fin_res;

  // One restoring step; the partial remainder is widened by a bit so divisors with the
  // MSB set cannot lose the shifted-out bit.
  always_comb begin
    rem_ext = {rem_q, quo_q[XLEN-1]};
    ge      = (rem_ext >= {1'b0, dvsr_q});
    rem_nxt = ge ? (rem_ext[XLEN-1:0] - dvsr_q) : rem_ext[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
    quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
    fin_res = spec_q ? spec_res_q : (is_rem_q ? rem_fix : quo_fix);
  end

  // Control FSM plus datapath registers; done and result are registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      spec_res_q <= '0;
      spec_q     <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && funct3[2]) begin
            quo_q      <= a_mag;
            rem_q      <= '0;
            dvsr_q     <= b_mag;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            is_rem_q   <= funct3[1];
            spec_q     <= special;
            spec_res_q <= spec_res;
            cnt_q      <= CntW'(XLEN - 1);
            if (EARLY_OUT && special) begin
              result_q <= spec_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            result_q <= fin_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          // start is ignored here so the retiring instruction is not re-issued
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stall  = ~flush & (((state_q == StIdle) & start & funct3[2]) | (state_q == StBusy));
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: XLEN=32 early-out instance and XLEN=64 full-latency one.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  logic        start64;
  logic [2:0]  funct3_64;
  logic [63:0] a64;
  logic [63:0] b64;
  logic        flush64;
  logic        stall64;
  logic        done64;
  logic [63:0] result64;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp64_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  iter_divider #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  iter_divider #(.XLEN(64), .EARLY_OUT(1'b0)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .funct3(funct3_64), .a(a64), .b(b64),
    .flush(flush64), .stall(stall64), .done(done64), .result(result64)
  );

  // Reference model following the RISC-V M-extension rules.
  function automatic logic [31:0] model32(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'd0) begin
      r = f3[1] ? x : 32'hFFFF_FFFF;
    end else if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = f3[1] ? 32'd0 : x;
    end else begin
      case (f3[1:0])
        2'b00:   r = $signed(x) / $signed(y);
        2'b01:   r = x / y;
        2'b10:   r = $signed(x) % $signed(y);
        default: r = x % y;
      endcase
    end
    return r;
  endfunction

  // Issue one op on the 32-bit unit, scramble operands while busy, check timing and result.
  task automatic run32(input string name, input logic [2:0] f3, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat);
    int cyc;
    int stalls;
    logic [31:0] want;
    @(negedge clk);
    start = 1'b1; funct3 = f3; a = x; b = y; flush = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s stall_at_accept: got %b expected 1", name, stall);
    end
    exp_q.push_back(exp);
    cyc = 0; stalls = 1;
    do begin
      @(negedge clk);
      cyc++;
      if (stall === 1'b1) stalls++;
      a = $urandom; b = $urandom;
    end while (done !== 1'b1 && cyc < lat + 10);
    want = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: got no done after %0d cycles expected %0d", name, cyc, lat);
    end else begin
      checks++;
      if (cyc != lat) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL %s stall_in_done: got %b expected 0", name, stall);
      end
      checks++;
      if (stalls != lat) begin
        errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, lat);
      end
      checks++;
      if (result !== want) begin
        errors++; $display("FAIL %s result: got %h expected %h", name, result, want);
      end
    end
    start = 1'b0;
    last_res = want;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; a = '0; b = '0; flush = 1'b0;
    start64 = 1'b0; funct3_64 = 3'b000; a64 = '0; b64 = '0; flush64 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset32: got res=%h done=%b stall=%b expected 0/0/0", result, done, stall);
    end
    checks++;
    if (result64 !== 64'd0 || done64 !== 1'b0 || stall64 !== 1'b0) begin
      errors++; $display("FAIL reset64: got res=%h done=%b stall=%b expected 0/0/0", result64, done64, stall64);
    end
    last_res = 32'd0;
  endtask

  task automatic test_ignore();
    int dones;
    int stalls;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b001; a = 32'd10; b = 32'd2;
    dones = 0; stalls = 0;
    repeat (6) begin
      #1;
      if (stall === 1'b1) stalls++;
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    checks++;
    if (stalls != 0 || dones != 0) begin
      errors++; $display("FAIL ignore_f3: got stalls=%0d dones=%0d expected 0/0", stalls, dones);
    end
  endtask

  task automatic test_basic();
    run32("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run32("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run32("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run32("remu_big",   3'b111, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
    run32("divu_msb",   3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run32("remu_msb",   3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
  endtask

  task automatic test_corner();
    run32("div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run32("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 1);
    run32("divu_by0", 3'b101, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
    run32("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run32("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  f3;
    for (int i = 0; i < 8; i++) begin
      x  = $urandom;
      y  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 3) y = 32'hFFFF_FFF3;
      f3 = {1'b1, 2'(i)};
      run32("random", f3, x, y, model32(f3, x, y), 33);
    end
  endtask

  task automatic test_flush();
    int dones;
    logic [31:0] prior;
    prior = last_res;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 32'd20; b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got stall=%b done=%b expected 0/0", stall, done);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL flush_no_done: got %0d dones expected 0", dones);
    end
    checks++;
    if (result !== prior) begin
      errors++; $display("FAIL flush_result: got %h expected %h", result, prior);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] want;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 32'd9; b = 32'd3;
    exp_q.push_back(32'd3);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 50);
    want = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || result !== want) begin
      errors++; $display("FAIL b2b_first: got done=%b res=%h expected 1/%h", done, result, want);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL b2b_done_stall: got %b expected 0", stall);
    end
    funct3 = 3'b111; a = 32'd9; b = 32'd4;
    exp_q.push_back(32'd1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 60);
    want = exp_q.pop_front();
    checks++;
    if (cyc != 34) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles expected 34", cyc);
    end
    checks++;
    if (done !== 1'b1 || result !== want) begin
      errors++; $display("FAIL b2b_second: got done=%b res=%h expected 1/%h", done, result, want);
    end
    start = 1'b0;
    last_res = want;
  endtask

  task automatic test_reset_mid_op();
    int dones;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
    repeat (6) @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset_mid: got stall=%b done=%b res=%h expected 0/0/0", stall, done, result);
    end
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d dones expected 0", dones);
    end
    last_res = 32'd0;
  endtask

  task automatic test_xlen64();
    int cyc;
    logic [63:0] want;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start64 = 1'b1;
      if (k == 0) begin
        funct3_64 = 3'b101; a64 = 64'd100; b64 = 64'd7;
        exp64_q.push_back(64'd14);
      end else begin
        funct3_64 = 3'b100; a64 = 64'd5; b64 = 64'd0;
        exp64_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      end
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (done64 !== 1'b1 && cyc < 80);
      start64 = 1'b0;
      want = exp64_q.pop_front();
      checks++;
      if (cyc != 65) begin
        errors++; $display("FAIL x64_latency_%0d: got %0d expected 65", k, cyc);
      end
      checks++;
      if (done64 !== 1'b1 || result64 !== want) begin
        errors++; $display("FAIL x64_result_%0d: got done=%b res=%h expected 1/%h", k, done64, result64, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_basic();
    test_corner();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
